font_text_gen: RTL

Pixel generator that reads the font ROM. It draws the fixed three-glyph string "ISA" (glyph codes 1, 2, 3) inside a rectangular text box on the VGA raster, with optional integer scaling and blinking. It sits between the VGA sync generator, which supplies pixel coordinates, and the RGB output register. It drives the font ROM address and consumes the ROM's one-cycle registered-read data.

---
 rtl/font_text_gen.sv | 115 +++++++++++
 1 files changed

// File: rtl/font_text_gen.sv
// font_text_gen: draws the glyph string "ISA" from an external font ROM inside a fixed
// text box on the VGA raster. Fixed 3-clk pipeline aligned to the ROM's registered read.
module font_text_gen #(
  parameter int unsigned X0           = 256,
  parameter int unsigned Y0           = 224,
  parameter int unsigned SCALE_LOG2   = 1,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic [11:0] FG           = 12'hFFF,
  parameter logic [11:0] BG           = 12'h000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pixel_tick,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        blink_en,
  output logic [5:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic [11:0] rgb,
  output logic        text_on
);

  localparam int unsigned CW    = 11;
  localparam int unsigned BOX_W = 24 << SCALE_LOG2;
  localparam int unsigned BOX_H = 16 << SCALE_LOG2;
  localparam int unsigned FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]   rel_x;
  logic [CW-1:0]   rel_y;
  logic            in_box_c;
  logic [1:0]      code_c;
  logic [3:0]      row_c;
  logic [2:0]      col_c;
  logic [5:0]      addr_c;
  logic            frame_start_c;
  logic            lit_c;

  logic [2:0]      col_d1;
  logic            in_box_d1;
  logic            video_d1;
  logic [2:0]      col_d2;
  logic            in_box_d2;
  logic            video_d2;

  logic [FC_W-1:0] frame_cnt;
  logic            visible;

  // Stage 0: box-relative coordinates; a negative offset shows up in bit 10
  always_comb begin
    rel_x    = {1'b0, pixel_x} - CW'(X0);
    rel_y    = {1'b0, pixel_y} - CW'(Y0);
    in_box_c = !rel_x[CW-1] && !rel_y[CW-1] &&
               (rel_x < CW'(BOX_W)) && (rel_y < CW'(BOX_H));
    code_c   = 2'(rel_x >> (3 + SCALE_LOG2)) + 2'd1;
    row_c    = 4'(rel_y >> SCALE_LOG2);
    col_c    = 3'(rel_x >> SCALE_LOG2);
    addr_c   = in_box_c ? {code_c, row_c} : 6'h00;
  end

  // Stages 1 and 2 run every clk so latency is independent of pixel_tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr  <= '0;
      col_d1    <= '0;
      in_box_d1 <= 1'b0;
      video_d1  <= 1'b0;
      col_d2    <= '0;
      in_box_d2 <= 1'b0;
      video_d2  <= 1'b0;
    end else begin
      rom_addr  <= addr_c;
      col_d1    <= col_c;
      in_box_d1 <= in_box_c;
      video_d1  <= video_on;
      col_d2    <= col_d1;
      in_box_d2 <= in_box_d1;
      video_d2  <= video_d1;
    end
  end

  assign frame_start_c = pixel_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);

  // Blink phase: blink_en low forces the glyphs on and restarts the frame count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      visible   <= 1'b1;
    end else if (!blink_en) begin
      frame_cnt <= '0;
      visible   <= 1'b1;
    end else if (frame_start_c) begin
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        visible   <= !visible;
      end else begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

  assign lit_c = in_box_d2 && rom_data[3'd7 - col_d2] && visible;

  // Stage 3: colour output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb     <= '0;
      text_on <= 1'b0;
    end else begin
      rgb     <= !video_d2 ? 12'h000 : (lit_c ? FG : BG);
      text_on <= lit_c && video_d2;
    end
  end

endmodule
